// File: rtl/desired_drive_pipe.sv
// Pipelined assist target current: condition, multiply, saturate, then slew-limit.
// One sample per cycle, fixed 5-edge latency, immediate zero when not pedaling.
module desired_drive_pipe #(
    parameter int                  TORQUE_W   = 12,
    parameter int                  CAD_W      = 5,
    parameter int                  SCALE_W    = 3,
    parameter int                  CURR_W     = 12,
    parameter logic [TORQUE_W-1:0] TORQUE_MIN = 12'h380,
    parameter int                  CAD_OFF    = 32,
    parameter int                  PROD_SHIFT = 15,
    parameter int                  SLEW_UP    = 64,
    parameter int                  SLEW_DN    = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                vld_in,
    input  logic [TORQUE_W-1:0] avg_torque,
    input  logic [CAD_W-1:0]    cadence,
    input  logic [12:0]         incline,
    input  logic [SCALE_W-1:0]  scale,
    input  logic                not_pedaling,
    output logic [CURR_W-1:0]   raw_curr,
    output logic [CURR_W-1:0]   target_curr,
    output logic                vld_out
);

    localparam int P1_W = TORQUE_W + 9;
    localparam int P2_W = P1_W + CAD_W + 1;
    localparam int P    = P2_W + SCALE_W;
    localparam int HI   = PROD_SHIFT + CURR_W;
    localparam logic [CURR_W:0] L_UP = (CURR_W+1)'(SLEW_UP);
    localparam logic [CURR_W:0] L_DN = (CURR_W+1)'(SLEW_DN);

    logic signed [12:0]   w_inc;
    logic signed [9:0]    w_inc_sat;
    logic signed [10:0]   w_inc_sum;
    logic [8:0]           w_inc_lim;
    logic [CAD_W:0]       w_cad_f;
    logic [TORQUE_W:0]    w_tq_d;
    logic [TORQUE_W-1:0]  w_tq;
    logic                 w_ovf;
    logic [CURR_W:0]      w_raw_x;
    logic [CURR_W:0]      w_tgt_x;
    logic [CURR_W:0]      w_up;
    logic [CURR_W:0]      w_dn;
    logic [CURR_W-1:0]    w_next;

    logic                 r_s1_v, r_s2_v, r_s3_v, r_s4_v, r_s5_v;
    logic                 r_s1_np, r_s2_np, r_s3_np, r_s4_np, r_s5_np;
    logic [TORQUE_W-1:0]  r_s1_tq;
    logic [8:0]           r_s1_lim;
    logic [CAD_W:0]       r_s1_cad, r_s2_cad;
    logic [SCALE_W-1:0]   r_s1_sc, r_s2_sc, r_s3_sc;
    logic [P1_W-1:0]      r_s2_p1;
    logic [P2_W-1:0]      r_s3_p2;
    logic [P-1:0]         r_s4_p3;
    logic [CURR_W-1:0]    r_s5_raw;
    logic [CURR_W-1:0]    r_raw;
    logic [CURR_W-1:0]    r_tgt;
    logic                 r_vld;

    assign w_inc = incline;

    always_comb begin
        w_inc_sat = w_inc[9:0];
        if (w_inc < -13'sd512)
            w_inc_sat = -10'sd512;
        else if (w_inc > 13'sd511)
            w_inc_sat = 10'sd511;
    end

    // Offset incline into 0..511; bit 10 = negative, bit 9 = above range
    assign w_inc_sum = {w_inc_sat[9], w_inc_sat} + 11'sd256;
    assign w_inc_lim = w_inc_sum[10] ? 9'd0
                     : (w_inc_sum[9] ? 9'd511 : w_inc_sum[8:0]);

    assign w_cad_f = (cadence > CAD_W'(1))
                   ? ({1'b0, cadence} + (CAD_W+1)'(CAD_OFF)) : '0;

    assign w_tq_d = {1'b0, avg_torque} - {1'b0, TORQUE_MIN};
    assign w_tq   = w_tq_d[TORQUE_W] ? '0 : w_tq_d[TORQUE_W-1:0];

    generate
        if (P > HI) begin : g_ovf
            assign w_ovf = |r_s4_p3[P-1:HI];
        end else begin : g_no_ovf
            assign w_ovf = 1'b0;
        end
    endgenerate

    assign w_raw_x = {1'b0, r_s5_raw};
    assign w_tgt_x = {1'b0, r_tgt};
    assign w_up    = w_raw_x - w_tgt_x;
    assign w_dn    = w_tgt_x - w_raw_x;

    always_comb begin
        w_next = r_tgt;
        if (r_s5_np) begin
            w_next = '0;
        end else if (w_raw_x > w_tgt_x) begin
            if (SLEW_UP == 0 || w_up <= L_UP)
                w_next = r_s5_raw;
            else
                w_next = CURR_W'(w_tgt_x + L_UP);
        end else if (w_raw_x < w_tgt_x) begin
            if (SLEW_DN == 0 || w_dn <= L_DN)
                w_next = r_s5_raw;
            else
                w_next = CURR_W'(w_tgt_x - L_DN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s2_v   <= 1'b0;
            r_s3_v   <= 1'b0;
            r_s4_v   <= 1'b0;
            r_s5_v   <= 1'b0;
            r_s1_np  <= 1'b0;
            r_s2_np  <= 1'b0;
            r_s3_np  <= 1'b0;
            r_s4_np  <= 1'b0;
            r_s5_np  <= 1'b0;
            r_s1_tq  <= '0;
            r_s1_lim <= '0;
            r_s1_cad <= '0;
            r_s1_sc  <= '0;
            r_s2_p1  <= '0;
            r_s2_cad <= '0;
            r_s2_sc  <= '0;
            r_s3_p2  <= '0;
            r_s3_sc  <= '0;
            r_s4_p3  <= '0;
            r_s5_raw <= '0;
            r_raw    <= '0;
            r_tgt    <= '0;
            r_vld    <= 1'b0;
        end else begin
            r_s1_v   <= vld_in;
            r_s1_np  <= not_pedaling;
            r_s1_tq  <= w_tq;
            r_s1_lim <= w_inc_lim;
            r_s1_cad <= w_cad_f;
            r_s1_sc  <= scale;

            r_s2_v   <= r_s1_v;
            r_s2_np  <= r_s1_np;
            r_s2_p1  <= P1_W'(r_s1_tq) * P1_W'(r_s1_lim);
            r_s2_cad <= r_s1_cad;
            r_s2_sc  <= r_s1_sc;

            r_s3_v   <= r_s2_v;
            r_s3_np  <= r_s2_np;
            r_s3_p2  <= P2_W'(r_s2_p1) * P2_W'(r_s2_cad);
            r_s3_sc  <= r_s2_sc;

            r_s4_v   <= r_s3_v;
            r_s4_np  <= r_s3_np;
            r_s4_p3  <= r_s3_np ? '0 : P'(r_s3_p2) * P'(r_s3_sc);

            r_s5_v   <= r_s4_v;
            r_s5_np  <= r_s4_np;
            r_s5_raw <= w_ovf ? '1 : r_s4_p3[HI-1:PROD_SHIFT];

            r_vld    <= r_s5_v;
            if (r_s5_v) begin
                r_raw <= r_s5_raw;
                r_tgt <= w_next;
            end
        end
    end

    assign raw_curr    = r_raw;
    assign target_curr = r_tgt;
    assign vld_out     = r_vld;

endmodule

// File: doc/desired_drive_pipe.md
Name: desired_drive_pipe

Overview:
- Parametrised, pipelined successor to the combinational desired-drive calculation.
- Computes assist target current from averaged torque, cadence, incline and scale. Accepts one sample per cycle and applies saturation at each stage.
- Adds an output slew-rate limiter with an immediate-zero path when the rider is not pedaling.
- Sits between the sensor/averaging blocks and the motor current controller.

Parameters:
- TORQUE_W, 12, avg_torque width
- CAD_W, 5, cadence width; cadence_factor width is CAD_W+1
- SCALE_W, 3, scale width
- CURR_W, 12, target current width
- TORQUE_MIN, 12'h380, torque offset subtracted before assist (width TORQUE_W)
- CAD_OFF, 32, offset added to cadence when cadence > 1
- PROD_SHIFT, 15, right shift applied to the product; require P >= PROD_SHIFT+CURR_W, where P = TORQUE_W+9+CAD_W+1+SCALE_W (default 30)
- SLEW_UP, 64, max target_curr increase per valid result; 0 = unlimited
- SLEW_DN, 256, max target_curr decrease per valid result; 0 = unlimited

Ports:
- clk, input, 1, clock
- rst_n, input, 1, asynchronous active-low reset
- vld_in, input, 1, sample strobe; inputs captured on the rising edge where vld_in=1
- avg_torque, input, TORQUE_W, unsigned averaged torque
- cadence, input, CAD_W, unsigned cadence
- incline, input, 13, signed incline
- scale, input, SCALE_W, unsigned assist scale
- not_pedaling, input, 1, forces zero assist
- raw_curr, output, CURR_W, unslewed saturated result
- target_curr, output, CURR_W, slew-limited target current
- vld_out, output, 1, one-cycle pulse per result

Behaviour:
- Reset (asynchronous, rst_n=0): all pipeline valids = 0; raw_curr = 0; target_curr = 0; vld_out = 0. Assertion mid-pipeline discards every in-flight sample. No vld_out is issued for samples captured before reset.
- No backpressure. A new sample may be accepted every cycle. Each stage carries its own valid bit and a copy of not_pedaling.
- Latency: a sample captured at edge N produces raw_curr, target_curr and vld_out=1 at edge N+5.
- S1, edge N, condition inputs:
  - incline_sat (10b signed): -512 if incline < -512; 511 if incline > 511; else incline[9:0].
  - incline_lim (9b) = clip(incline_sat+256, 0, 511), computed in 11b signed.
  - cadence_factor = (cadence > 1) ? cadence+CAD_OFF : 0, in CAD_W+1 bits.
  - torque_pos = max(avg_torque - TORQUE_MIN, 0), computed in TORQUE_W+1 bits.
- S2, edge N+1: p1 = torque_pos * incline_lim.
- S3, edge N+2: p2 = p1 * cadence_factor.
- S4, edge N+3: p3 = p2 * scale, P bits. Forced to 0 if the staged not_pedaling=1.
- S5, edge N+4: raw = all-ones if any of p3[P-1:PROD_SHIFT+CURR_W] is set; else p3[PROD_SHIFT+CURR_W-1:PROD_SHIFT].
- Output stage, edge N+5:
  - raw_curr <= raw; vld_out <= 1.
  - If staged not_pedaling=1: target_curr <= 0 immediately, ignoring SLEW_DN.
  - Else if raw > target_curr: target_curr += min(raw - target_curr, SLEW_UP), or takes raw directly if SLEW_UP = 0.
  - Else if raw < target_curr: target_curr -= min(target_curr - raw, SLEW_DN), or takes raw directly if SLEW_DN = 0.
  - Else: target_curr unchanged.
- Slew arithmetic: done in CURR_W+1 bits. target_curr never overshoots raw and never wraps.
- No valid result at a given edge: target_curr and raw_curr hold; vld_out = 0.
- Back-to-back vld_in: one slew step per result, applied in order.

Test Plan:
- Nominal: avg_torque=0x780, incline=0, cadence=16, scale=4, vld_in one cycle -> vld_out at edge +5, raw_curr=0x600, target_curr=0x040 (SLEW_UP=64).
- Ramp: repeat the nominal sample each cycle -> target_curr steps 0x040, 0x080, … and reaches 0x600 on the 24th result, then holds. vld_out is high every cycle.
- Saturation: avg_torque=0xFFF, incline=13'h0FF0, cadence=31, scale=7 -> raw_curr=0xFFF. Incline=-300 or cadence=1 or avg_torque=0x37F -> raw_curr=0.
- Decay and kill: after target_curr=0x600, apply raw=0x000 with pedaling -> 0x500, 0x400, …. Asserting not_pedaling instead -> target_curr=0 on that result's edge.
- Reset mid-operation: three samples in flight, pulse rst_n low -> outputs 0 immediately, no vld_out for those samples. A new sample after release gives the normal 5-edge latency.
- Parameter sweep: SLEW_UP=SLEW_DN=0, CURR_W=10, PROD_SHIFT=17 -> target_curr equals raw_curr each result; a model compare over 10k random samples gives no mismatches.
